// File: rtl/dco_seq_pkg.sv
// Shared state/class encodings and tuning-word field boundaries for the DCO update sequencer.
package dco_seq_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, HOLD, SETTLE} seq_state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_COARSE, CLS_FINE, CLS_DSM} upd_class_t;

  localparam int CODE_W    = 13;
  localparam int COARSE_HI = 12;
  localparam int COARSE_LO = 8;
  localparam int FINE_HI   = 7;
  localparam int FINE_LO   = 4;
  localparam int DSM_HI    = 3;
  localparam int DSM_LO    = 0;

  // The most significant field that moves decides which decoder flops must reload.
  function automatic upd_class_t classify_change(input logic [CODE_W-1:0] old_code,
                                                 input logic [CODE_W-1:0] new_code);
    upd_class_t cls;
    cls = CLS_NONE;
    if (old_code[COARSE_HI:COARSE_LO] != new_code[COARSE_HI:COARSE_LO])
      cls = CLS_COARSE;
    else if (old_code[FINE_HI:FINE_LO] != new_code[FINE_HI:FINE_LO])
      cls = CLS_FINE;
    else if (old_code[DSM_HI:DSM_LO] != new_code[DSM_HI:DSM_LO])
      cls = CLS_DSM;
    return cls;
  endfunction

endpackage

// File: rtl/dco_step_calc.sv
// Combinational step engine: clamps requests, computes the bounded next code and its update class.
module dco_step_calc
  import dco_seq_pkg::*;
#(
  parameter int          MAX_STEP = 16,
  parameter logic [12:0] MAX_CODE = 13'h13FF
) (
  input  logic [12:0] req_code,
  input  logic [12:0] cur_code,
  input  logic [12:0] target,
  output logic [12:0] clamp_code,
  output logic        over_max,
  output logic [12:0] next_code,
  output logic [1:0]  step_class,
  output logic        at_target
);

  localparam logic [12:0] STEP_LIMIT = 13'(MAX_STEP);

  logic        step_up;
  logic [12:0] distance;
  logic [12:0] step;

  // Distance is taken in the step direction so the result can never wrap past 0 or 8191.
  always_comb begin
    over_max   = req_code > MAX_CODE;
    clamp_code = over_max ? MAX_CODE : req_code;
    at_target  = cur_code == target;
    step_up    = target > cur_code;
    distance   = step_up ? (target - cur_code) : (cur_code - target);
    step       = (distance > STEP_LIMIT) ? STEP_LIMIT : distance;
    next_code  = step_up ? (cur_code + step) : (cur_code - step);
    step_class = classify_change(cur_code, next_code);
  end

endmodule

// File: rtl/dco_update_sequencer.sv
// Slews the DCO decoder code toward requested targets and drives per-field reload windows.
// Optional build macro DCO_SEQ_PREEMPT_EN: accept a new target during SETTLE.
module dco_update_sequencer
  import dco_seq_pkg::*;
#(
  parameter int          MAX_STEP   = 16,
  parameter int          HOLD_CYC   = 2,
  parameter int          SETTLE_CYC = 4,
  parameter logic [12:0] RESET_CODE = 13'h0800,
  parameter logic [12:0] MAX_CODE   = 13'h13FF
) (
  input  logic        dco_clk,
  input  logic        reset2,
  input  logic        req_valid,
  input  logic [12:0] req_code,
  output logic        req_ready,
  output logic [12:0] filter_output,
  output logic        logic1,
  output logic        logic2,
  output logic        logic3,
  output logic        logic1_posedge,
  output logic        logic2_posedge,
  output logic        logic3_posedge,
  output logic        busy,
  output logic        done,
  output logic        clamped
);

`ifdef DCO_SEQ_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  seq_state_t  state, next_state;
  upd_class_t  cls;
  logic [15:0] cnt;
  logic [12:0] target;
  logic        clamp_pending;
  logic        done_pending;

  logic        accept;
  logic        ready_next;
  logic        window_on;
  logic [12:0] clamp_code;
  logic        over_max;
  logic [12:0] next_code;
  logic [1:0]  step_class;
  logic        at_target;

  dco_step_calc #(
    .MAX_STEP (MAX_STEP),
    .MAX_CODE (MAX_CODE)
  ) u_step_calc (
    .req_code   (req_code),
    .cur_code   (filter_output),
    .target     (target),
    .clamp_code (clamp_code),
    .over_max   (over_max),
    .next_code  (next_code),
    .step_class (step_class),
    .at_target  (at_target)
  );

  assign accept = req_valid & req_ready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LOAD;
      LOAD:    next_state = at_target ? IDLE : STROBE;
      STROBE:  next_state = (HOLD_CYC == 1) ? SETTLE : HOLD;
      HOLD:    if (cnt == 16'(HOLD_CYC - 2)) next_state = SETTLE;
      SETTLE: begin
        if (PREEMPT && accept)
          next_state = LOAD;
        else if (cnt == 16'(SETTLE_CYC - 1))
          next_state = at_target ? IDLE : LOAD;
      end
      default: next_state = IDLE;
    endcase
    ready_next = (next_state == IDLE) || (PREEMPT && (next_state == SETTLE));
    window_on  = (state == STROBE) || (state == HOLD);
  end

  // Window outputs are registered from the current state, so they trail the code update by one
  // edge and the decoder always sees a stable code for the whole window.
  always_ff @(posedge dco_clk) begin
    if (!reset2) begin
      state          <= IDLE;
      cnt            <= '0;
      target         <= RESET_CODE;
      filter_output  <= RESET_CODE;
      cls            <= CLS_NONE;
      clamp_pending  <= 1'b0;
      done_pending   <= 1'b0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      clamped        <= 1'b0;
      logic1         <= 1'b0;
      logic2         <= 1'b0;
      logic3         <= 1'b0;
      logic1_posedge <= 1'b0;
      logic2_posedge <= 1'b0;
      logic3_posedge <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= (next_state != state) ? 16'd0 : cnt + 16'd1;
      req_ready <= ready_next;
      busy      <= next_state != IDLE;

      if (accept) begin
        target        <= clamp_code;
        clamp_pending <= over_max;
      end else if (state == LOAD) begin
        clamp_pending <= 1'b0;
      end

      if ((state == LOAD) && !at_target) begin
        filter_output <= next_code;
        cls           <= upd_class_t'(step_class);
      end

      clamped      <= (state == LOAD) && clamp_pending;
      done_pending <= (state == SETTLE) && (next_state == IDLE);
      done         <= done_pending || ((state == LOAD) && at_target);

      logic1         <= window_on && (cls == CLS_COARSE);
      logic2         <= window_on && (cls == CLS_FINE);
      logic3         <= window_on && (cls == CLS_DSM);
      logic1_posedge <= (state == STROBE) && (cls == CLS_COARSE);
      logic2_posedge <= (state == STROBE) && (cls == CLS_FINE);
      logic3_posedge <= (state == STROBE) && (cls == CLS_DSM);
    end
  end

endmodule

// File: tb/tb_dco_update_sequencer.sv
// Self-checking bench: a cycle timeline of expected outputs is built per accepted request from the slew rules.
module tb_dco_update_sequencer;

  localparam int          HOLD_CYC   = 2;
  localparam int          SETTLE_CYC = 4;
  localparam int          MAX_STEP   = 16;
  localparam int          ROUND      = 1 + HOLD_CYC + SETTLE_CYC;
  localparam logic [12:0] RESET_CODE = 13'h0800;
  localparam logic [12:0] MAX_CODE   = 13'h13FF;
  localparam int          DEPTH      = 32768;
`ifdef DCO_SEQ_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic        dco_clk   = 1'b0;
  logic        reset2    = 1'b0;
  logic        req_valid = 1'b0;
  logic [12:0] req_code  = '0;
  logic        req_ready, logic1, logic2, logic3;
  logic        logic1_posedge, logic2_posedge, logic3_posedge, busy, done, clamped;
  logic [12:0] filter_output;

  dco_update_sequencer dut (
    .dco_clk        (dco_clk),
    .reset2         (reset2),
    .req_valid      (req_valid),
    .req_code       (req_code),
    .req_ready      (req_ready),
    .filter_output  (filter_output),
    .logic1         (logic1),
    .logic2         (logic2),
    .logic3         (logic3),
    .logic1_posedge (logic1_posedge),
    .logic2_posedge (logic2_posedge),
    .logic3_posedge (logic3_posedge),
    .busy           (busy),
    .done           (done),
    .clamped        (clamped)
  );

  always #5 dco_clk = ~dco_clk;

  // Expected outputs per cycle; exp_win holds the active class (0 none, 1 coarse, 2 fine, 3 DSM).
  logic [12:0] exp_fo      [DEPTH];
  logic [1:0]  exp_win     [DEPTH];
  logic        exp_pe      [DEPTH];
  logic        exp_busy    [DEPTH];
  logic        exp_ready   [DEPTH];
  logic        exp_done    [DEPTH];
  logic        exp_clamped [DEPTH];

  int cyc         = -1;
  int last_filled = -1;
  int last_done   = 0;
  bit started     = 1'b0;
  bit acc_flag    = 1'b0;
  int n_cmp       = 0;
  int n_fail      = 0;

  function automatic void checkOutput(string name, logic [12:0] actual, logic [12:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
    end
  endfunction

  function automatic logic [1:0] field_class(logic [12:0] a, logic [12:0] b);
    if (a[12:8] != b[12:8]) return 2'd1;
    if (a[7:4] != b[7:4]) return 2'd2;
    if (a[3:0] != b[3:0]) return 2'd3;
    return 2'd0;
  endfunction

  function automatic void set_frame(int i, logic [12:0] fo, logic [1:0] win, logic pe,
                                    logic bsy, logic rdy);
    exp_fo[i]    = fo;
    exp_win[i]   = win;
    exp_pe[i]    = pe;
    exp_busy[i]  = bsy;
    exp_ready[i] = rdy;
  endfunction

  function automatic void fill_to(int c);
    while (last_filled < c) begin
      last_filled++;
      set_frame(last_filled, exp_fo[last_filled-1], 2'd0, 1'b0, 1'b0, 1'b1);
    end
  endfunction

  // Plan the whole slew: each round is a load cycle, the window, then the settle gap.
  function automatic void model_accept(int a, logic [12:0] raw);
    logic [12:0] code, tgt, nxt;
    logic [1:0]  cls;
    int          s, diff, step;
    code = exp_fo[a-1];
    tgt  = (raw > MAX_CODE) ? MAX_CODE : raw;
    for (int i = a + 1; i < DEPTH; i++) begin
      exp_done[i]    = 1'b0;
      exp_clamped[i] = 1'b0;
    end
    exp_clamped[a+1] = raw > MAX_CODE;
    if (tgt == code) begin
      set_frame(a, code, 2'd0, 1'b0, 1'b1, 1'b0);
      exp_done[a+1] = 1'b1;
      last_done     = a + 1;
      last_filled   = a;
      return;
    end
    s = a;
    while (code != tgt) begin
      diff = (tgt > code) ? int'(tgt) - int'(code) : int'(code) - int'(tgt);
      step = (diff > MAX_STEP) ? MAX_STEP : diff;
      nxt  = (tgt > code) ? code + 13'(step) : code - 13'(step);
      cls  = field_class(code, nxt);
      for (int o = 0; o < ROUND; o++)
        set_frame(s + o, (o == 0) ? code : nxt, (o >= 2 && o <= HOLD_CYC + 1) ? cls : 2'd0,
                  o == 2, 1'b1, PREEMPT && (o > HOLD_CYC));
      code = nxt;
      s += ROUND;
    end
    last_filled   = s - 1;
    exp_done[s+1] = 1'b1;
    last_done     = s + 1;
  endfunction

  task automatic tick();
    @(posedge dco_clk);
    cyc++;
    if (cyc > DEPTH - 6000) begin
      $display("[TB] FAIL cycle_budget cycle %0d: got overrun expected < %0d", cyc, DEPTH - 6000);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    if (!reset2) begin
      set_frame(cyc, RESET_CODE, 2'd0, 1'b0, 1'b0, 1'b1);
      for (int i = cyc; i < DEPTH; i++) begin
        exp_done[i]    = 1'b0;
        exp_clamped[i] = 1'b0;
      end
      last_filled = cyc;
      last_done   = cyc;
      started     = 1'b1;
    end else begin
      if (req_valid && exp_ready[cyc-1]) begin
        model_accept(cyc, req_code);
        acc_flag = 1'b1;
      end
      fill_to(cyc);
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [12:0] code, output int acc_cycle);
    int budget;
    req_code  = code;
    req_valid = 1'b1;
    acc_flag  = 1'b0;
    budget    = 4000;
    while (!acc_flag && budget > 0) begin
      tick();
      budget--;
    end
    if (!acc_flag) checkOutput("accept_timeout", 13'd0, 13'd1);
    acc_cycle = cyc;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int budget;
    budget = 4000;
    while (!(exp_busy[cyc] == 1'b0 && cyc >= last_done) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) checkOutput("idle_timeout", 13'd0, 13'd1);
  endtask

  task automatic pulseReset();
    reset2 = 1'b0;
    tick();
    reset2 = 1'b1;
  endtask

  always @(negedge dco_clk) begin
    if (started && cyc >= 0) begin
      checkOutput("filter_output", filter_output, exp_fo[cyc]);
      checkOutput("logic1", 13'(logic1), 13'(exp_win[cyc] == 2'd1));
      checkOutput("logic2", 13'(logic2), 13'(exp_win[cyc] == 2'd2));
      checkOutput("logic3", 13'(logic3), 13'(exp_win[cyc] == 2'd3));
      checkOutput("logic1_posedge", 13'(logic1_posedge), 13'(exp_pe[cyc] && exp_win[cyc] == 2'd1));
      checkOutput("logic2_posedge", 13'(logic2_posedge), 13'(exp_pe[cyc] && exp_win[cyc] == 2'd2));
      checkOutput("logic3_posedge", 13'(logic3_posedge), 13'(exp_pe[cyc] && exp_win[cyc] == 2'd3));
      checkOutput("busy", 13'(busy), 13'(exp_busy[cyc]));
      checkOutput("req_ready", 13'(req_ready), 13'(exp_ready[cyc]));
      checkOutput("done", 13'(done), 13'(exp_done[cyc]));
      checkOutput("clamped", 13'(clamped), 13'(exp_clamped[cyc]));
    end
  end

  initial begin
    int a;
    int c;
    for (int i = 0; i < DEPTH; i++) begin
      exp_done[i]    = 1'b0;
      exp_clamped[i] = 1'b0;
    end

    repeat (3) tick();
    reset2 = 1'b1;
    repeat (3) tick();
    checkOutput("pin_reset_fo", exp_fo[cyc], 13'h0800);
    checkOutput("pin_reset_ready", 13'(exp_ready[cyc]), 13'd1);

    applyStimulus(13'h0805, a);
    checkOutput("pin_0805_fo_c1", exp_fo[a+1], 13'h0805);
    checkOutput("pin_0805_win_c2", 13'(exp_win[a+2]), 13'd3);
    checkOutput("pin_0805_pe_c2", 13'(exp_pe[a+2]), 13'd1);
    checkOutput("pin_0805_win_c3", 13'(exp_win[a+3]), 13'd3);
    checkOutput("pin_0805_win_c4", 13'(exp_win[a+4]), 13'd0);
    checkOutput("pin_0805_done_c8", 13'(exp_done[a+8]), 13'd1);
    waitIdle();

    pulseReset();
    tick();
    applyStimulus(13'h0830, a);
    checkOutput("pin_0830_fo_r1", exp_fo[a+1], 13'h0810);
    checkOutput("pin_0830_fo_r2", exp_fo[a+8], 13'h0820);
    checkOutput("pin_0830_fo_r3", exp_fo[a+15], 13'h0830);
    checkOutput("pin_0830_win", 13'(exp_win[a+16]), 13'd2);
    checkOutput("pin_0830_done_c22", 13'(exp_done[a+22]), 13'd1);
    waitIdle();

    applyStimulus(13'h08F8, a);
    waitIdle();
    applyStimulus(13'h0902, a);
    checkOutput("pin_0902_fo", exp_fo[a+1], 13'h0902);
    checkOutput("pin_0902_win", 13'(exp_win[a+2]), 13'd1);
    waitIdle();

    applyStimulus(13'h1FFF, a);
    checkOutput("pin_clamp_c1", 13'(exp_clamped[a+1]), 13'd1);
    waitIdle();
    checkOutput("pin_clamp_final", exp_fo[cyc], 13'h13FF);

    applyStimulus(13'h13FF, a);
    checkOutput("pin_equal_done_c1", 13'(exp_done[a+1]), 13'd1);
    waitIdle();

    applyStimulus(13'h1300, a);
    tick();
    tick();
    pulseReset();
    checkOutput("pin_hold_reset_fo", exp_fo[a+3], 13'h0800);
    checkOutput("pin_hold_reset_busy", 13'(exp_busy[a+3]), 13'd0);
    repeat (ROUND + 3) tick();

`ifdef DCO_SEQ_PREEMPT_EN
    applyStimulus(13'h0830, a);
    repeat (3) tick();
    applyStimulus(13'h0900, c);
    checkOutput("pin_preempt_fo", exp_fo[c+1], 13'h0820);
    waitIdle();
    checkOutput("pin_preempt_final", exp_fo[cyc], 13'h0900);
`endif

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)
        c = 'h1400 + int'($urandom_range(0, 'hBFF));
      else if (r == 1)
        c = int'(exp_fo[cyc]);
      else
        c = int'(exp_fo[cyc]) + int'($urandom_range(0, 300)) - 150;
      if (c < 0) c = 0;
      if (c > 'h1FFF) c = 'h1FFF;
      applyStimulus(13'(c), a);
      repeat ($urandom_range(0, 3 * ROUND)) tick();
      if ($urandom_range(0, 12) == 0) pulseReset();
    end
    waitIdle();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
